dst4x4_fwd: RTL and testbench
=============================

# dst4x4_fwd

Sequential forward 4x4 DST-VII engine: accepts a 4x4 block of signed residuals, computes Y = M·X·Mᵀ with the integer DST-VII matrix, and emits a 24-bit unscaled coefficient block. It sits directly upstream of `normalize` (IN_W=24, SHIFT=14), which rounds and shifts the output to 16 bits. The engine runs two 1-D passes of four cycles each on shared constant multipliers. Handshakes on both sides are valid/ready.

## Interface
Parameters:
- IN_W, 9, residual sample width, signed.
- MID_W, 16, intermediate (post-pass-1) width, signed. Must satisfy MID_W ≥ IN_W+8−SHIFT1.
- OUT_W, 24, coefficient width, signed. Must satisfy OUT_W ≥ MID_W+8. Matches `normalize` IN_W.
- SHIFT1, 1, rounding right-shift applied after pass 1.

Ports:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous, active-high reset.
- in_valid, in, 1, in_block is valid.
- in_ready, out, 1, engine can accept a block.
- in_block, in, [0:3][0:3] × IN_W, residual block X[row][col].
- out_valid, out, 1, out_block holds a finished result.
- out_ready, in, 1, downstream accepts out_block.
- out_block, out, [0:3][0:3] × OUT_W, coefficients Y[row][col].

## Operation
- Matrix M, with k as the row index:
  - k=0: [29 55 74 84]
  - k=1: [74 74 0 −74]
  - k=2: [84 −29 −74 55]
  - k=3: [55 −84 74 −29]
- FSM states: IDLE, PASS1, PASS2, DONE. A 2-bit counter cnt is used in PASS1 and PASS2.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, register in_block into X, set cnt=0, go to PASS1.
- PASS1:
  - Each cycle, process column j=cnt.
  - T[k][j] = (Σn M[k][n]·X[n][j] + 2^(SHIFT1−1)) >>> SHIFT1, for k=0..3.
  - The sum is full precision (IN_W+8 bits). The result is stored at MID_W bits with no saturation; the default widths make overflow impossible.
  - At cnt=3, set cnt=0 and go to PASS2.
- PASS2:
  - Each cycle, process row i=cnt.
  - Y[i][k] = Σn T[i][n]·M[k][n]. This is exact with no shift or saturation.
  - Write Y into the out_block register.
  - At cnt=3, go to DONE.
- DONE:
  - out_valid=1 and out_block is held stable.
  - On out_ready, go to IDLE.
  - in_valid is ignored while busy; in_ready=0 in PASS1, PASS2 and DONE.
- in_ready and out_valid are decoded from the state register.
- Reset:
  - State goes to IDLE, cnt=0, X/T/out_block are cleared to all zeros, out_valid=0.
  - in_ready=0 in any cycle where rst=1.
  - Reset mid-operation abandons the block; no output is produced for it.

## Timing
- E0 is the accept edge (in_valid && in_ready).
- PASS1 computes on E1–E4 and PASS2 on E5–E8.
- out_valid rises after E8, i.e. 8 cycles after acceptance.
- The output handshake completes at edge E9 or later. in_ready returns the cycle after that edge.
- Peak throughput is one block per 10 cycles with out_ready held at 1.
- out_block changes only during PASS2 and on reset. It must never change while out_valid=1.
- No combinational path exists from in_valid or out_ready to any output.

## Test plan
- **Reset/idle:** hold rst for 3 cycles, then release.
  - out_valid=0 and out_block all 0 throughout.
  - in_ready=0 during rst, 1 on the first cycle after.
- **DC block:** all X=1, out_ready=1.
  - out_valid exactly 8 cycles after accept.
  - Row 0 = [29282 8954 4356 1936], row 1 = [8954 2738 1332 592].
  - Row 2 = [4356 1332 648 288], row 3 = [1936 592 288 128].
- **Impulse:** X[0][0]=1, all others 0.
  - Y[i][k] = c_i·M[k][0], with c = [15 37 42 28].
  - Y[0][0]=435, Y[0][1]=1110, Y[3][3]=1540.
- **Extreme negative:** all X=−256.
  - Y[0][0] = −7496192, with no overflow.
  - Feeding this into `normalize` with SHIFT=14 yields a value consistent with −7496192 >>> 14 after rounding.
- **Backpressure:** out_ready=0 for 5 cycles after out_valid rises, with in_valid=1 and a different block presented.
  - out_block stays stable and in_ready stays 0.
  - After out_ready=1, the second block is accepted and its result is correct.
- **Reset mid-PASS2:** assert rst 6 cycles after accept.
  - No out_valid is produced.
  - The next block is accepted and produces correct results.

Source files
------------

// File: rtl/dst4x4_fwd.sv
// rtl/dst4x4_fwd.sv - sequential forward 4x4 DST-VII engine, column pass then row pass
module dst4x4_fwd #(
    parameter int IN_W   = 9,
    parameter int MID_W  = 16,
    parameter int OUT_W  = 24,
    parameter int SHIFT1 = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [0:3][0:3][IN_W-1:0]         in_block_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [0:3][0:3][OUT_W-1:0]        out_block_o
);

    localparam int SUM1_W = IN_W + 8;
    localparam logic signed [SUM1_W-1:0] RND1 = SUM1_W'(1) << (SHIFT1 - 1);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    logic signed [IN_W-1:0]    x_q [4][4];
    logic signed [MID_W-1:0]   t_q [4][4];
    logic [0:3][0:3][OUT_W-1:0] y_q;

    logic signed [SUM1_W-1:0]  acc1 [4];
    logic signed [MID_W-1:0]   t_col [4];
    logic signed [OUT_W-1:0]   acc2 [4];

    // Integer DST-VII basis, k selects the basis function (row of M)
    function automatic logic signed [7:0] m_coef(input logic [1:0] k, input logic [1:0] n);
        case ({k, n})
            4'h0:    return 8'sd29;
            4'h1:    return 8'sd55;
            4'h2:    return 8'sd74;
            4'h3:    return 8'sd84;
            4'h4:    return 8'sd74;
            4'h5:    return 8'sd74;
            4'h6:    return 8'sd0;
            4'h7:    return -8'sd74;
            4'h8:    return 8'sd84;
            4'h9:    return -8'sd29;
            4'hA:    return -8'sd74;
            4'hB:    return 8'sd55;
            4'hC:    return 8'sd55;
            4'hD:    return -8'sd84;
            4'hE:    return 8'sd74;
            default: return -8'sd29;
        endcase
    endfunction

    // Pass 1: transform column cnt of X, round and shift into the intermediate width
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            acc1[k] = RND1;
            for (int n = 0; n < 4; n++) begin
                acc1[k] = acc1[k] + SUM1_W'(x_q[n][cnt_q]) * SUM1_W'(m_coef(2'(k), 2'(n)));
            end
            t_col[k] = MID_W'(acc1[k] >>> SHIFT1);
        end
    end

    // Pass 2: transform row cnt of T exactly, no rounding
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            acc2[k] = '0;
            for (int n = 0; n < 4; n++) begin
                acc2[k] = acc2[k] + OUT_W'(t_q[cnt_q][n]) * OUT_W'(m_coef(2'(k), 2'(n)));
            end
        end
    end

    // Next state, pass counter and handshake outputs decoded from the state register
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = !rst_i;
                if (in_valid_i) begin
                    state_d = PASS1;
                    cnt_d   = 2'd0;
                end
            end
            PASS1: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = PASS2;
                    cnt_d   = 2'd0;
                end
            end
            PASS2: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                    cnt_d   = 2'd0;
                end
            end
            default: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State, input capture, intermediate and result registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            y_q     <= '0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    x_q[r][c] <= '0;
                    t_q[r][c] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && in_valid_i) begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        x_q[r][c] <= $signed(in_block_i[r][c]);
                    end
                end
            end
            if (state_q == PASS1) begin
                for (int k = 0; k < 4; k++) begin
                    t_q[k][cnt_q] <= t_col[k];
                end
            end
            if (state_q == PASS2) begin
                for (int k = 0; k < 4; k++) begin
                    y_q[cnt_q][k] <= acc2[k];
                end
            end
        end
    end

    assign out_block_o = y_q;

endmodule

// File: tb/tb_dst4x4_fwd.sv
// tb/tb_dst4x4_fwd.sv - directed and random checks of dst4x4_fwd against a matrix model
module tb_dst4x4_fwd;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [0:3][0:3][8:0]      in_block;
    logic                      out_valid;
    logic                      out_ready;
    logic [0:3][0:3][23:0]     out_block;

    int n_checks = 0;
    int n_fail   = 0;

    int mm [4][4] = '{'{29, 55, 74, 84}, '{74, 74, 0, -74}, '{84, -29, -74, 55}, '{55, -84, 74, -29}};
    int xin [4][4];
    int ey  [4][4];
    logic [0:3][0:3][23:0] snap;

    dst4x4_fwd dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_block_i  (in_block),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_block_o (out_block)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Y = M * X * M^T with the first product rounded by one bit
    task automatic model();
        int t [4][4];
        int s;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int n = 0; n < 4; n++) s += mm[k][n] * xin[n][j];
                t[k][j] = (s + 1) >>> 1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                s = 0;
                for (int n = 0; n < 4; n++) s += t[i][n] * mm[k][n];
                ey[i][k] = s;
            end
        end
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) xin[r][c] = v;
    endtask

    task automatic fill_random();
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) xin[r][c] = int'($urandom_range(511)) - 256;
    endtask

    task automatic drive_block();
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) in_block[r][c] = xin[r][c][8:0];
    endtask

    function automatic int y_at(input int r, input int c);
        return int'($signed(out_block[r][c]));
    endfunction

    task automatic accept(input string tag, input bit keep_valid);
        drive_block();
        in_valid = 1'b1;
        check({tag, "_in_ready_before_accept"}, int'(in_ready), 1);
        tick();
        in_valid = keep_valid;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 8);
    endtask

    task automatic check_out(input string tag);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                check($sformatf("%s_y%0d%0d", tag, r, c), y_at(r, c), ey[r][c]);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        check({tag, "_out_valid_dropped"}, int'(out_valid), 0);
        check({tag, "_in_ready_back"}, int'(in_ready), 1);
    endtask

    task automatic run_block(input string tag);
        model();
        out_ready = 1'b1;
        accept(tag, 1'b0);
        wait_valid(tag);
        check_out(tag);
        release_out(tag);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_block = '0;

        // reset and idle
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_in_ready", int'(in_ready), 0);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out_block_zero", int'(|out_block), 0);
        end
        rst = 1'b0;
        #1;
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_out_block_zero", int'(|out_block), 0);

        // DC block
        fill_const(1);
        model();
        out_ready = 1'b1;
        accept("dc", 1'b0);
        wait_valid("dc");
        check_out("dc");
        check("dc_y00_const", y_at(0, 0), 29282);
        check("dc_y01_const", y_at(0, 1), 8954);
        check("dc_y22_const", y_at(2, 2), 648);
        check("dc_y33_const", y_at(3, 3), 128);
        release_out("dc");

        // impulse
        fill_const(0);
        xin[0][0] = 1;
        model();
        accept("imp", 1'b0);
        wait_valid("imp");
        check_out("imp");
        check("imp_y00_const", y_at(0, 0), 435);
        check("imp_y01_const", y_at(0, 1), 1110);
        check("imp_y33_const", y_at(3, 3), 1540);
        release_out("imp");

        // extreme negative
        fill_const(-256);
        run_block("neg");
        check("neg_y00_ref", ey[0][0], -7496192);

        // random blocks
        for (int b = 0; b < 6; b++) begin
            fill_random();
            run_block($sformatf("rnd%0d", b));
        end

        // backpressure with a second block waiting
        fill_random();
        model();
        out_ready = 1'b0;
        accept("bp_a", 1'b1);
        fill_random();
        drive_block();
        wait_valid("bp_a");
        check_out("bp_a");
        snap = out_block;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_stable", int'(out_block === snap), 1);
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_in_ready", int'(in_ready), 0);
        end
        model();
        out_ready = 1'b1;
        tick();
        check("bp_b_in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        wait_valid("bp_b");
        check_out("bp_b");
        release_out("bp_b");

        // reset during pass 2
        fill_random();
        accept("mid", 1'b0);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_out_block_cleared", int'(|out_block), 0);
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("mid_no_out_valid", int'(seen), 0);
        fill_random();
        run_block("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
